// File: rtl/data_memory_arbiter.sv
// Arbiter that shares one registered-read data-memory port between the core load/store
// path and a host/DMA loader, stalling the core while its load data is in flight.
module data_memory_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            core_req,
    input  logic            core_write,
    input  logic [XLEN-1:0] core_address,
    input  logic [XLEN-1:0] core_write_data,
    output logic [XLEN-1:0] core_read_data,
    output logic            core_stall,
    input  logic            loader_req,
    output logic            loader_ready,
    input  logic            loader_write,
    input  logic [XLEN-1:0] loader_address,
    input  logic [XLEN-1:0] loader_write_data,
    output logic [XLEN-1:0] loader_read_data,
    output logic            loader_read_valid,
    output logic            mem_enable,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_write_data,
    input  logic [XLEN-1:0] mem_read_data
);

    localparam int unsigned CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CORE_RD = 2'd1,
        LDR_RD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic [XLEN-1:0]    core_rd_q, ldr_rd_q;
    logic               grant_core, grant_ldr;

    // Issue decision: only in IDLE, core by default, loader once it has waited long enough.
    always_comb begin
        grant_core = 1'b0;
        grant_ldr  = 1'b0;
        if (!reset && state_q == IDLE) begin
            if (loader_req && (!core_req || starve_q >= CNT_W'(STARVE_LIMIT))) begin
                grant_ldr = 1'b1;
            end else if (core_req) begin
                grant_core = 1'b1;
            end
        end
    end

    always_comb begin
        mem_enable     = grant_core | grant_ldr;
        mem_write      = grant_ldr ? loader_write : (grant_core & core_write);
        mem_address    = grant_ldr ? loader_address : core_address;
        mem_write_data = grant_ldr ? loader_write_data : core_write_data;
        loader_ready   = grant_ldr;

        // Load return cycle releases the core; a pending loader return holds it.
        core_stall = 1'b0;
        if (!reset && core_req) begin
            unique case (state_q)
                IDLE:    core_stall = grant_ldr | (grant_core & ~core_write);
                CORE_RD: core_stall = 1'b0;
                LDR_RD:  core_stall = 1'b1;
                default: core_stall = 1'b0;
            endcase
        end

        loader_read_valid = !reset && state_q == LDR_RD;
        core_read_data    = (state_q == CORE_RD) ? mem_read_data : core_rd_q;
        loader_read_data  = (state_q == LDR_RD) ? mem_read_data : ldr_rd_q;
    end

    always_comb begin
        state_d = IDLE;
        unique case (state_q)
            IDLE: begin
                if (grant_core && !core_write) begin
                    state_d = CORE_RD;
                end else if (grant_ldr && !loader_write) begin
                    state_d = LDR_RD;
                end
            end
            CORE_RD: state_d = IDLE;
            LDR_RD:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        starve_d = starve_q;
        if (!loader_req || grant_ldr) begin
            starve_d = '0;
        end else if (starve_q != CNT_MAX) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            core_rd_q <= '0;
            ldr_rd_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            if (state_q == CORE_RD) begin
                core_rd_q <= mem_read_data;
            end
            if (state_q == LDR_RD) begin
                ldr_rd_q <= mem_read_data;
            end
        end
    end

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares the single data-memory port between the core datapath's load/store path and a loader port. The loader is a host/DMA side that preloads AES keys and plaintext and reads back ciphertext.
- The data memory has a registered (1-cycle latency) read, so the arbiter stalls the core by deasserting its PC/regfile write enables until a load's data returns or a store is granted.
- It sits between the core datapath, the core control unit and the data memory.

Parameters:
- XLEN, 32, data and address width.
- STARVE_LIMIT, 4, number of consecutive cycles the loader may be denied before it gets priority over the core. Legal range 1..15.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- core_req  input  1  core has a load or store this cycle; held stable while core_stall=1
- core_write  input  1  1=store, 0=load
- core_address  input  XLEN  byte address from ALU result
- core_write_data  input  XLEN  store data (rs2)
- core_read_data  output  XLEN  load data to writeback mux
- core_stall  output  1  control gates pc_write_enable and regfile_write_enable with !core_stall
- loader_req  input  1  loader request valid
- loader_ready  output  1  request accepted when loader_req && loader_ready
- loader_write  input  1  1=write, 0=read
- loader_address  input  XLEN  byte address
- loader_write_data  input  XLEN  write data
- loader_read_data  output  XLEN  read data, valid when loader_read_valid
- loader_read_valid  output  1  single-cycle pulse
- mem_enable  output  1  memory access this cycle
- mem_write  output  1  write strobe, only with mem_enable
- mem_address  output  XLEN  to memory
- mem_write_data  output  XLEN  to memory
- mem_read_data  input  XLEN  data for the read issued in the previous cycle

Behaviour:
- Clock is `clock`. Reset is `reset`: one clock, synchronous, active-high.
- FSM states:
  - IDLE: may issue.
  - CORE_RD: core load data returning.
  - LDR_RD: loader read data returning.
- Issue is allowed only in IDLE. No issue happens in CORE_RD or LDR_RD, so mem_enable=0 there.
- Arbitration in IDLE:
  - Core only requests: grant core.
  - Loader only requests: grant loader.
  - Both request: grant core, unless starve_cnt >= STARVE_LIMIT, then grant loader.
- starve_cnt (4-bit):
  - Increments when loader_req=1 and the loader is not granted in any state.
  - Saturates at 15.
  - Clears on loader grant, or when loader_req=0.
- Grant outputs, combinational in the issue cycle: mem_enable=1, and mem_write/mem_address/mem_write_data come from the winner. loader_ready=1 only in the loader-grant cycle.
- Core store granted: core_stall=0 in that same cycle; the write commits at the edge and the state stays IDLE.
- Core load granted: core_stall=1 and next state is CORE_RD. In CORE_RD, core_read_data=mem_read_data, core_stall=0, then IDLE. Load latency is 2 cycles, including one stall.
- Core request not granted (loader wins): core_stall=1.
- core_stall=0 whenever core_req=0.
- Loader write granted: stays IDLE.
- Loader read granted: next state is LDR_RD. There, loader_read_valid=1 and loader_read_data=mem_read_data for one cycle, then IDLE.
- core_read_data and loader_read_data hold their last value when not valid (registered copy of mem_read_data captured in the return state).
- While reset=1, combinationally: core_stall=0, loader_ready=0, mem_enable=0, mem_write=0.
- Reset values: state=IDLE, starve_cnt=0, loader_read_valid=0, core_read_data=0, loader_read_data=0.
- Reset mid-read drops the pending return: no loader_read_valid pulse, and core_stall=0.
- Address/data are passed unmodified. Alignment and byte masks are out of scope; word accesses only.
- Back-to-back throughput:
  - Core stores or loader writes: 1 per cycle.
  - Reads: 1 per 2 cycles.

Test Plan:
- Core store alone: core_req=1, core_write=1, addr 0x100, data 0xDEADBEEF. Required: mem_enable=mem_write=1 same cycle, core_stall=0, no state change.
- Core load alone: addr 0x100, memory holds 0xDEADBEEF. Required:
  - cycle 0: core_stall=1, mem_enable=1, mem_write=0;
  - cycle 1: core_stall=0, core_read_data=0xDEADBEEF, mem_enable=0.
- Loader read: loader_req=1 at addr 0x40 holding 0x01234567. Required: loader_ready=1 in cycle 0, then loader_read_valid pulse with 0x01234567 in cycle 1 only.
- Contention/starvation (STARVE_LIMIT=4): core issues continuous stores and loader_req is held. Required: core granted 4 cycles, loader granted in cycle 4 with core_stall=1 that cycle, then core resumes and starve_cnt=0.
- Simultaneous core load and loader write in IDLE with starve_cnt=0. Required: core wins; in CORE_RD loader_ready=0 and starve_cnt increments; loader is granted the following cycle.
- Reset asserted during LDR_RD. Required: next cycle state=IDLE, loader_read_valid=0, core_stall=0, starve_cnt=0, and no memory access while reset=1.
